// File: rtl/lc3b_types.sv
// Shared line/tag types and the eviction write buffer state encoding.
package lc3b_types;

  localparam int LINE_OFFSET_BITS = 4;

  typedef logic [127:0] lc3b_c_line;
  typedef logic [15-LINE_OFFSET_BITS:0] lc3b_c_tag;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    RESP  = 2'd3
  } ewb_state_t;

  function automatic lc3b_c_tag line_tag(input logic [15:0] addr);
    return addr[15:LINE_OFFSET_BITS];
  endfunction

endpackage

// File: rtl/ewb_entry.sv
// Single buffered line: valid/tag/data registers with a combinational tag match.
module ewb_entry
  import lc3b_types::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       clear,
  input  lc3b_c_tag  load_tag,
  input  lc3b_c_line load_data,
  input  lc3b_c_tag  cmp_tag,
  output logic       valid,
  output lc3b_c_tag  tag,
  output lc3b_c_line data,
  output logic       hit
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      tag   <= '0;
      data  <= '0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      tag   <= load_tag;
      data  <= load_data;
    end
  end

  assign hit = valid && (tag == cmp_tag);

endmodule

// File: rtl/eviction_write_buffer.sv
// Single-entry eviction buffer between the L1 cache and pmem: miss reads bypass
// the buffered write-back, which drains once the bus has been idle long enough.
//
// state | meaning
// IDLE  | accept cache requests, count idle cycles while a line is buffered
// FETCH | miss read outstanding on pmem
// DRAIN | buffered line being written to pmem; always runs to completion
// RESP  | one-cycle c_resp; cache inputs ignored
module eviction_write_buffer
  import lc3b_types::*;
#(
  parameter int DRAIN_DELAY = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [15:0]  c_address,
  input  logic         c_read,
  input  logic         c_write,
  input  logic [127:0] c_wdata,
  output logic [127:0] c_rdata,
  output logic         c_resp,
  output logic [15:0]  pmem_address,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [127:0] pmem_wdata,
  input  logic [127:0] pmem_rdata,
  input  logic         pmem_resp
);

  localparam int CNT_W = (DRAIN_DELAY > 0) ? $clog2(DRAIN_DELAY + 1) : 1;
  localparam logic [CNT_W-1:0] DELAY_CNT = CNT_W'(DRAIN_DELAY);

  ewb_state_t       state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;

  logic       entry_load, entry_clear, entry_valid, entry_hit;
  lc3b_c_tag  entry_tag;
  lc3b_c_line entry_data;
  lc3b_c_tag  req_tag;

  logic rdata_from_buf, rdata_from_pmem, addr_miss, start_drain;

  // Offset bits select a word inside the line; the buffer works on whole lines.
  logic unused_offset;
  assign unused_offset = ^c_address[LINE_OFFSET_BITS-1:0];

  assign req_tag = line_tag(c_address);

  ewb_entry u_entry (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (entry_load),
    .clear     (entry_clear),
    .load_tag  (req_tag),
    .load_data (c_wdata),
    .cmp_tag   (req_tag),
    .valid     (entry_valid),
    .tag       (entry_tag),
    .data      (entry_data),
    .hit       (entry_hit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next      = state;
    cnt_next        = cnt;
    entry_load      = 1'b0;
    entry_clear     = 1'b0;
    rdata_from_buf  = 1'b0;
    rdata_from_pmem = 1'b0;
    addr_miss       = 1'b0;
    start_drain     = 1'b0;
    case (state)
      IDLE: begin
        // Read wins over a simultaneous write and over a pending drain.
        if (c_read) begin
          cnt_next = '0;
          if (entry_hit) begin
            rdata_from_buf = 1'b1;
            state_next     = RESP;
          end else begin
            addr_miss  = 1'b1;
            state_next = FETCH;
          end
        end else if (c_write) begin
          cnt_next = '0;
          if (entry_valid) begin
            start_drain = 1'b1;
            state_next  = DRAIN;
          end else begin
            entry_load = 1'b1;
            state_next = RESP;
          end
        end else if (entry_valid) begin
          if (cnt == DELAY_CNT) begin
            cnt_next    = '0;
            start_drain = 1'b1;
            state_next  = DRAIN;
          end else begin
            cnt_next = cnt + CNT_W'(1);
          end
        end else begin
          cnt_next = '0;
        end
      end
      FETCH: begin
        if (pmem_resp) begin
          rdata_from_pmem = 1'b1;
          state_next      = RESP;
        end
      end
      DRAIN: begin
        if (pmem_resp) begin
          entry_clear = 1'b1;
          cnt_next    = '0;
          state_next  = IDLE;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt          <= '0;
      c_rdata      <= '0;
      pmem_address <= '0;
      pmem_wdata   <= '0;
    end else begin
      cnt <= cnt_next;
      if (rdata_from_buf)       c_rdata <= entry_data;
      else if (rdata_from_pmem) c_rdata <= pmem_rdata;
      if (addr_miss) begin
        pmem_address <= {req_tag, {LINE_OFFSET_BITS{1'b0}}};
      end else if (start_drain) begin
        pmem_address <= {entry_tag, {LINE_OFFSET_BITS{1'b0}}};
        pmem_wdata   <= entry_data;
      end
    end
  end

  assign pmem_read  = (state == FETCH);
  assign pmem_write = (state == DRAIN);
  assign c_resp     = (state == RESP);

endmodule

// File: tb/tb_eviction_write_buffer.sv
// Directed bench for eviction_write_buffer with hand-computed expectations.
module tb_eviction_write_buffer;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [15:0]  c_address;
  logic         c_read, c_write;
  logic [127:0] c_wdata, c_rdata;
  logic         c_resp;
  logic [15:0]  pmem_address;
  logic         pmem_read, pmem_write;
  logic [127:0] pmem_wdata, pmem_rdata;
  logic         pmem_resp;

  localparam logic [127:0] DATA_A = 128'h0123456789ABCDEF0123456789ABCDEF;
  localparam logic [127:0] DATA_B = 128'hB0B0B0B0_11112222_33334444_B0B0B0B0;
  localparam logic [127:0] DATA_C = 128'hC0FFEE00_C0FFEE01_C0FFEE02_C0FFEE03;
  localparam logic [127:0] DATA_D = 128'hDDDD0000_DDDD1111_DDDD2222_DDDD3333;
  localparam logic [127:0] DATA_E = 128'hEEEE5555_EEEE6666_EEEE7777_EEEE8888;
  localparam logic [127:0] RD_1   = 128'h11111111_22222222_33333333_44444444;
  localparam logic [127:0] RD_2   = 128'h80008000_DEADBEEF_80008000_CAFEF00D;
  localparam logic [127:0] RD_3   = 128'h4A504A50_00000000_FFFFFFFF_4A504A50;
  localparam logic [127:0] RD_4   = 128'h30003000_ABCDABCD_30003000_12341234;

  int n_checks = 0;
  int n_errors = 0;
  int rd_cyc = 0, wr_cyc = 0, resp_cyc = 0, resp_pulses = 0;
  logic resp_prev = 1'b0;

  eviction_write_buffer #(.DRAIN_DELAY(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .c_address    (c_address),
    .c_read       (c_read),
    .c_write      (c_write),
    .c_wdata      (c_wdata),
    .c_rdata      (c_rdata),
    .c_resp       (c_resp),
    .pmem_address (pmem_address),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_wdata   (pmem_wdata),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (pmem_read)  rd_cyc++;
    if (pmem_write) wr_cyc++;
    if (c_resp) resp_cyc++;
    if (c_resp && !resp_prev) resp_pulses++;
    resp_prev = c_resp;
  end

  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_pmem(input int bound);
    int i = 0;
    while (!(pmem_read || pmem_write) && i < bound) begin
      tick();
      i++;
    end
    check_val("pmem_strobe_wait", {127'b0, pmem_read | pmem_write}, 128'd1);
  endtask

  task automatic wait_c_resp(input int bound);
    int i = 0;
    while (!c_resp && i < bound) begin
      tick();
      i++;
    end
    check_val("c_resp_wait", {127'b0, c_resp}, 128'd1);
  endtask

  // Answer the outstanding pmem strobe in its lat-th cycle.
  task automatic serve(input int lat, input logic [127:0] rd);
    wait_pmem(20);
    repeat (lat - 1) tick();
    pmem_rdata = rd;
    pmem_resp  = 1'b1;
    tick();
    pmem_resp  = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0, w0, p0, c0, early;
    rst_n = 1'b0; c_address = '0; c_read = 1'b0; c_write = 1'b0;
    c_wdata = '0; pmem_rdata = '0; pmem_resp = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_c_resp",   {127'b0, c_resp}, 128'd0);
    check_val("rst_c_rdata",  c_rdata, 128'd0);
    check_val("rst_pmem_rd",  {127'b0, pmem_read}, 128'd0);
    check_val("rst_pmem_wr",  {127'b0, pmem_write}, 128'd0);
    check_val("rst_pmem_adr", {112'b0, pmem_address}, 128'd0);
    check_val("rst_pmem_wd",  pmem_wdata, 128'd0);
    rst_n = 1'b1;
    tick();

    // Reset in the middle of a drain
    c_address = 16'h1110; c_wdata = DATA_D; c_write = 1'b1;
    wait_c_resp(10);
    c_write = 1'b0;
    wait_pmem(10);
    check_val("pre_rst_drain_wr",  {127'b0, pmem_write}, 128'd1);
    check_val("pre_rst_drain_adr", {112'b0, pmem_address}, 128'h1110);
    rst_n = 1'b0;
    #1;
    check_val("async_rst_wr",  {127'b0, pmem_write}, 128'd0);
    check_val("async_rst_adr", {112'b0, pmem_address}, 128'd0);
    check_val("async_rst_wd",  pmem_wdata, 128'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();
    c_address = 16'h1230; c_read = 1'b1;
    tick();
    check_val("post_rst_miss_rd",  {127'b0, pmem_read}, 128'd1);
    check_val("post_rst_miss_adr", {112'b0, pmem_address}, 128'h1230);
    serve(2, RD_1);
    check_val("post_rst_resp",  {127'b0, c_resp}, 128'd1);
    check_val("post_rst_rdata", c_rdata, RD_1);
    c_read = 1'b0;
    w0 = wr_cyc;
    repeat (6) tick();
    check_val("no_drain_after_rst", 128'(wr_cyc - w0), 128'd0);

    // Write into empty buffer, then read hit
    r0 = rd_cyc; w0 = wr_cyc;
    c_address = 16'h4A50; c_wdata = DATA_A; c_write = 1'b1;
    tick();
    check_val("wr_empty_resp", {127'b0, c_resp}, 128'd1);
    c_write = 1'b0;
    tick();
    check_val("wr_empty_resp_1cyc", {127'b0, c_resp}, 128'd0);
    c_address = 16'h4A5E; c_read = 1'b1;
    tick();
    check_val("hit_resp",  {127'b0, c_resp}, 128'd1);
    check_val("hit_rdata", c_rdata, DATA_A);
    check_val("hit_no_pmem", 128'((rd_cyc - r0) + (wr_cyc - w0)), 128'd0);

    // Miss read bypasses the buffered line, drain follows after idle delay
    c_address = 16'h8000;
    wait_pmem(10);
    check_val("miss_read_first", {126'b0, pmem_write, pmem_read}, 128'd1);
    check_val("miss_adr", {112'b0, pmem_address}, 128'h8000);
    serve(5, RD_2);
    check_val("miss_resp",  {127'b0, c_resp}, 128'd1);
    check_val("miss_rdata", c_rdata, RD_2);
    c_read = 1'b0;
    early = 0;
    repeat (3) begin
      tick();
      if (pmem_write) early++;
    end
    check_val("drain_not_early", 128'(early), 128'd0);
    tick();
    check_val("drain_start", {127'b0, pmem_write}, 128'd1);
    check_val("drain_adr", {112'b0, pmem_address}, 128'h4A50);
    check_val("drain_wd",  pmem_wdata, DATA_A);
    pmem_resp = 1'b1;
    tick();
    pmem_resp = 1'b0;
    check_val("drain_done", {127'b0, pmem_write}, 128'd0);
    c_address = 16'h4A50; c_read = 1'b1;
    tick();
    check_val("buf_cleared_miss", {127'b0, pmem_read}, 128'd1);
    serve(1, RD_3);
    check_val("probe_rdata", c_rdata, RD_3);
    c_read = 1'b0;
    tick();

    // Write to a valid buffer forces a drain first
    c_address = 16'h1000; c_wdata = DATA_B; c_write = 1'b1;
    tick();
    check_val("wr_b_resp", {127'b0, c_resp}, 128'd1);
    c_write = 1'b0;
    tick();
    c_address = 16'h2000; c_wdata = DATA_C; c_write = 1'b1;
    tick();
    check_val("evict_drain", {127'b0, pmem_write}, 128'd1);
    check_val("evict_adr", {112'b0, pmem_address}, 128'h1000);
    check_val("evict_wd",  pmem_wdata, DATA_B);
    pmem_resp = 1'b1;
    tick();
    pmem_resp = 1'b0;
    check_val("evict_back_idle", {126'b0, pmem_write, c_resp}, 128'd0);
    tick();
    check_val("evict_accept", {127'b0, c_resp}, 128'd1);
    c_write = 1'b0;
    tick();
    r0 = rd_cyc;
    c_address = 16'h2008; c_read = 1'b1;
    tick();
    check_val("new_tag_hit",   {127'b0, c_resp}, 128'd1);
    check_val("new_tag_rdata", c_rdata, DATA_C);
    check_val("new_tag_no_rd", 128'(rd_cyc - r0), 128'd0);
    c_read = 1'b0;
    tick();

    // Read and write held together: read first, then drain, then write
    p0 = resp_pulses; c0 = resp_cyc;
    c_address = 16'h3000; c_wdata = DATA_E; c_read = 1'b1; c_write = 1'b1;
    tick();
    check_val("both_read_first", {126'b0, pmem_write, pmem_read}, 128'd1);
    check_val("both_read_adr", {112'b0, pmem_address}, 128'h3000);
    serve(3, RD_4);
    check_val("both_read_resp",  {127'b0, c_resp}, 128'd1);
    check_val("both_read_rdata", c_rdata, RD_4);
    c_read = 1'b0;
    tick();
    tick();
    check_val("both_drain", {127'b0, pmem_write}, 128'd1);
    check_val("both_drain_adr", {112'b0, pmem_address}, 128'h2000);
    check_val("both_drain_wd", pmem_wdata, DATA_C);
    pmem_resp = 1'b1;
    tick();
    pmem_resp = 1'b0;
    tick();
    check_val("both_write_resp", {127'b0, c_resp}, 128'd1);
    c_write = 1'b0;
    tick();
    tick();
    check_val("both_pulse_count", 128'(resp_pulses - p0), 128'd2);
    check_val("both_pulse_width", 128'(resp_cyc - c0), 128'd2);
    c_address = 16'h300C; c_read = 1'b1;
    tick();
    check_val("both_wr_hit", c_rdata, DATA_E);
    c_read = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/eviction_write_buffer.md
Name: eviction_write_buffer

Overview:
- Single-entry victim/eviction buffer between the 2-way L1 cache (cache_control/datapath) and physical memory.
- Absorbs a dirty-line write-back in one cycle so the cache can issue its miss fetch immediately.
- Forwards miss reads to pmem ahead of the buffered write and drains the buffered line when the bus goes idle.
- Returns buffered data directly when a read hits the buffered line.

Parameters:
- DRAIN_DELAY, 2, idle cycles (no cache request) in IDLE with buffer valid before a drain starts; 0 = drain on first idle cycle.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst_n  input  1  asynchronous active-low reset.
- c_address  input  16  cache-side line address; bits [3:0] ignored.
- c_read  input  1  cache line read request; held until c_resp.
- c_write  input  1  cache line write (eviction) request; held until c_resp.
- c_wdata  input  128  eviction line data.
- c_rdata  output  128  read line data; valid while c_resp=1.
- c_resp  output  1  one-cycle completion pulse.
- pmem_address  output  16  physical memory line address, bits [3:0]=0.
- pmem_read  output  1  pmem read strobe.
- pmem_write  output  1  pmem write strobe.
- pmem_wdata  output  128  pmem write data.
- pmem_rdata  input  128  pmem read data.
- pmem_resp  input  1  pmem completion.

Behaviour:
- Storage: buf_valid, buf_tag[15:4], buf_data[127:0]; idle counter sized to hold DRAIN_DELAY.
- States: IDLE, FETCH, DRAIN, RESP.
- pmem_read, pmem_write, c_resp are decoded from the state register only. No combinational path from c_* to pmem_* or c_resp.
- Reset (async, rst_n=0): state=IDLE, buf_valid=0, counter=0; c_resp=0, c_rdata=0, pmem_read=0, pmem_write=0, pmem_address=0, pmem_wdata=0. A mid-operation reset drops strobes immediately, and any buffered line is discarded.
- IDLE, c_read with buf_valid && c_address[15:4]==buf_tag (hit): c_rdata<=buf_data, go RESP. c_resp is high in the cycle after the request is sampled.
- IDLE, c_read miss: pmem_address<=line address, go FETCH. The read takes priority over a pending drain, regardless of the counter.
- IDLE, c_write with !buf_valid: capture tag/data, buf_valid<=1, go RESP.
- IDLE, c_write with buf_valid: go DRAIN immediately, ignoring the counter. The write is accepted on return to IDLE.
- IDLE, c_read and c_write both high: illegal. The read is serviced first and the write waits.
- IDLE, no request, buf_valid: counter++. When counter==DRAIN_DELAY, go DRAIN. Any request or !buf_valid clears the counter.
- FETCH: pmem_read=1. On pmem_resp: c_rdata<=pmem_rdata, go RESP.
- DRAIN: pmem_write=1, pmem_address={buf_tag,4'b0}, pmem_wdata=buf_data. On pmem_resp: buf_valid<=0, counter<=0, go IDLE.
- A drain, once started, always completes. A read arriving during DRAIN waits until then.
- RESP: c_resp=1 for exactly one cycle, then IDLE. c_* inputs are not sampled in RESP, which prevents double acceptance of a held request.
- Coherence: a write to a tag equal to a valid buf_tag still goes DRAIN-then-accept. No merging.

Decomposition:
- Add to lc3b_types:
  - lc3b_c_line (128-bit line)
  - lc3b_c_tag (12-bit line tag, address[15:4])
  - LINE_OFFSET_BITS=4
  - enum ewb_state_t {IDLE, FETCH, DRAIN, RESP}
- One sub-module, ewb_entry: valid/tag/data registers with load, clear, and a combinational tag-match output.
- FSM and counter stay in eviction_write_buffer.

Test Plan:
- Reset mid-DRAIN (rst_n low 1 cycle while pmem_write=1) -> pmem_write=0 asynchronously; after release, c_read 0x1230 misses and pmem_read is asserted.
- Empty buffer, c_write 0x4A50 data 0x0123..CDEF -> c_resp 1 cycle after the request, no pmem activity. Then c_read 0x4A5E -> hit, c_rdata=0x0123..CDEF, pmem_read never asserted.
- Buffer valid with 0x4A50, c_read 0x8000 next cycle, pmem_resp after 5 cycles -> pmem_read first with pmem_address=0x8000, c_resp carries pmem_rdata. Drain then starts DRAIN_DELAY=2 idle cycles later with pmem_address=0x4A50, and buf_valid clears on pmem_resp.
- Buffer valid with 0x1000, c_write 0x2000 -> DRAIN of 0x1000 starts next cycle. After pmem_resp, the write is accepted, c_resp pulses, and the buffer holds tag 0x200.
- c_read 0x3000 and c_write both held -> read serviced first, write accepted afterwards. c_resp pulses exactly twice, each one cycle wide.
